// File: rtl/sine_burst_ctrl.sv
// Burst sequencer for a sine generator: gates the generator via its reset so that each
// burst restarts at phase zero, and produces a linear attack/release amplitude envelope.
`timescale 1ns/1ps

// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; generator held in reset
// RAMP_UP   | attack, envelope rises (k+1)/RAMP_CYCLES
// HOLD      | full amplitude for on_cycles
// RAMP_DOWN | release, envelope falls (RAMP_CYCLES-1-k)/RAMP_CYCLES
// GAP       | generator held in reset between bursts, at least one cycle
// DONE      | single-cycle completion pulse
module sine_burst_ctrl #(
  parameter int RAMP_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_count,
  input  logic [CNT_W-1:0] on_cycles,
  input  logic [CNT_W-1:0] off_cycles,
  output logic             gen_rst_n,
  output logic             gen_gate,
  output real              amp_scale,
  output logic [CNT_W-1:0] burst_idx,
  output logic             busy,
  output logic             done
);

  localparam int RW = $clog2(RAMP_CYCLES + 1);
  localparam int CW = (CNT_W > RW) ? CNT_W : RW;
  localparam logic [CW-1:0]    RAMP_LAST = CW'(RAMP_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    RAMP_CW   = CW'(RAMP_CYCLES);
  localparam logic [RW-1:0]    RAMP_FULL = RW'(RAMP_CYCLES);
  localparam logic [CNT_W-1:0] IDX_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_HOLD,
    S_RAMP_DOWN,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic             gen_q, gen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RW-1:0]    amp_num_q, amp_num_d;
  logic             in_busy;

  assign in_busy = (state_q == S_RAMP_UP) || (state_q == S_HOLD) ||
                   (state_q == S_RAMP_DOWN) || (state_q == S_GAP);

  // cnt_q is a per-phase down-counter; the phase ends when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    count_d = count_q;
    on_d    = on_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          count_d = burst_count;
          on_d    = on_cycles;
          off_d   = off_cycles;
          idx_d   = '0;
          cnt_d   = RAMP_LAST;
          state_d = (burst_count == '0) ? S_DONE : S_RAMP_UP;
        end
      end
      S_RAMP_UP: begin
        if (cnt_q == '0) begin
          if (on_q == '0) begin
            state_d = S_RAMP_DOWN;
            cnt_d   = RAMP_LAST;
          end else begin
            state_d = S_HOLD;
            cnt_d   = CW'(on_q) - CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_RAMP_DOWN;
          cnt_d   = RAMP_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RAMP_DOWN: begin
        if (cnt_q == '0) begin
          if (idx_q == count_q - IDX_ONE) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_GAP;
            idx_d   = idx_q + IDX_ONE;
            // a zero gap still gives the generator one reset cycle
            cnt_d   = (off_q == '0) ? '0 : CW'(off_q) - CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_RAMP_UP;
          cnt_d   = RAMP_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort && in_busy) begin
      state_d = S_DONE;
      cnt_d   = '0;
      idx_d   = idx_q;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    gen_d     = (state_d == S_RAMP_UP) || (state_d == S_HOLD) || (state_d == S_RAMP_DOWN);
    busy_d    = gen_d || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
    amp_num_d = '0;
    case (state_d)
      S_RAMP_UP:   amp_num_d = RW'(RAMP_CW - cnt_d);
      S_HOLD:      amp_num_d = RAMP_FULL;
      S_RAMP_DOWN: amp_num_d = RW'(cnt_d);
      default:     amp_num_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      on_q      <= '0;
      off_q     <= '0;
      gen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      amp_num_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      on_q      <= on_d;
      off_q     <= off_d;
      gen_q     <= gen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      amp_num_q <= amp_num_d;
    end
  end

  // Integer numerator keeps the envelope exact with no accumulated error.
  assign amp_scale = real'(amp_num_q) / real'(RAMP_CYCLES);
  assign gen_rst_n = gen_q;
  assign gen_gate  = gen_q;
  assign burst_idx = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sine_burst_ctrl.sv
// Self-checking bench for sine_burst_ctrl: directed scenarios plus randomized sequences
// compared cycle by cycle against a trace built from the burst timing rules.
`timescale 1ns/1ps

module tb_sine_burst_ctrl;

  localparam int R = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] burst_count;
  logic [15:0] on_cycles;
  logic [15:0] off_cycles;
  logic        gen_rst_n;
  logic        gen_gate;
  real         amp_scale;
  logic [15:0] burst_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        gen;
    logic        gate;
    logic        busy;
    logic        done;
    logic [15:0] idx;
    real         amp;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];

  sine_burst_ctrl #(.RAMP_CYCLES(R), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .burst_count(burst_count), .on_cycles(on_cycles), .off_cycles(off_cycles),
    .gen_rst_n(gen_rst_n), .gen_gate(gen_gate), .amp_scale(amp_scale),
    .burst_idx(burst_idx), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic real rabs(real x);
    return (x < 0.0) ? -x : x;
  endfunction

  function automatic rec_t mk(logic g, logic b, logic d, int idx, real amp);
    rec_t r;
    r.gen = g; r.gate = g; r.busy = b; r.done = d; r.idx = 16'(idx); r.amp = amp;
    return r;
  endfunction

  function automatic rec_t sample();
    rec_t r;
    r.gen = gen_rst_n; r.gate = gen_gate; r.busy = busy; r.done = done;
    r.idx = burst_idx; r.amp = amp_scale;
    return r;
  endfunction

  // Expected outputs for cycles 1..n after the start edge; abort_at is the cycle during
  // which abort is held high (sampled at the following edge), or -1.
  function automatic void build_exp(int cnt, int on, int off, int n, int abort_at);
    rec_t t[$];
    int   gap;
    int   last;
    gap = (off < 1) ? 1 : off;
    for (int b = 0; b < cnt; b++) begin
      for (int k = 0; k < R; k++) t.push_back(mk(1, 1, 0, b, real'(k + 1) / real'(R)));
      for (int k = 0; k < on; k++) t.push_back(mk(1, 1, 0, b, 1.0));
      for (int k = 0; k < R; k++) t.push_back(mk(1, 1, 0, b, real'(R - 1 - k) / real'(R)));
      if (b < cnt - 1)
        for (int k = 0; k < gap; k++) t.push_back(mk(0, 1, 0, b + 1, 0.0));
    end
    t.push_back(mk(0, 0, 1, (cnt == 0) ? 0 : cnt - 1, 0.0));
    if (abort_at >= 1 && abort_at <= t.size() && t[abort_at - 1].busy) begin
      last = int'(t[abort_at - 1].idx);
      while (t.size() > abort_at) void'(t.pop_back());
      t.push_back(mk(0, 0, 1, last, 0.0));
    end
    while (t.size() < n) t.push_back(mk(0, 0, 0, int'(t[t.size() - 1].idx), 0.0));
    while (t.size() > n) void'(t.pop_back());
    exp_q = t;
  endfunction

  task automatic run_seq(input int cnt, input int on, input int off, input int n,
                         input int abort_at, input int start_at, input bit scramble);
    obs_q = {};
    @(posedge clk);
    #1;
    burst_count = 16'(cnt);
    on_cycles   = 16'(on);
    off_cycles  = 16'(off);
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      burst_count = 16'($urandom_range(0, 5));
      on_cycles   = 16'($urandom_range(0, 7));
      off_cycles  = 16'($urandom_range(0, 5));
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      obs_q.push_back(sample());
      abort = (i == abort_at);
      start = (i == start_at);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (gen_rst_n !== 1'b0 || gen_gate !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        burst_idx !== 16'd0 || amp_scale != 0.0) begin
      errors++;
      $display("FAIL reset_in: got gen=%b gate=%b busy=%b done=%b idx=%0d amp=%0.4f expected all zero",
               gen_rst_n, gen_gate, busy, done, burst_idx, amp_scale);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gen_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || amp_scale != 0.0) begin
      errors++;
      $display("FAIL reset_idle: got gen=%b busy=%b done=%b amp=%0.4f expected all zero",
               gen_rst_n, busy, done, amp_scale);
    end
  endtask

  task automatic test_basic();
    run_seq(2, 3, 2, 30, -1, -1, 1'b0);
    build_exp(2, 3, 2, 30, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].gen !== exp_q[i].gen || obs_q[i].gate !== exp_q[i].gen ||
          obs_q[i].busy !== exp_q[i].busy || obs_q[i].done !== exp_q[i].done ||
          obs_q[i].idx !== exp_q[i].idx || rabs(obs_q[i].amp - exp_q[i].amp) > 1e-9) begin
        errors++;
        $display("FAIL basic_trace cycle %0d: got gen=%b gate=%b busy=%b done=%b idx=%0d amp=%0.4f expected gen=%b busy=%b done=%b idx=%0d amp=%0.4f",
                 i + 1, obs_q[i].gen, obs_q[i].gate, obs_q[i].busy, obs_q[i].done, obs_q[i].idx, obs_q[i].amp,
                 exp_q[i].gen, exp_q[i].busy, exp_q[i].done, exp_q[i].idx, exp_q[i].amp);
      end
    end
    checks++;
    if (obs_q[24].done !== 1'b1 || obs_q[24].busy !== 1'b0 || obs_q[23].done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_at_25: got done=%b busy=%b (cycle 24 done=%b) expected done=1 busy=0",
               obs_q[24].done, obs_q[24].busy, obs_q[23].done);
    end
    checks++;
    if (obs_q[10].gen !== 1'b1 || obs_q[11].gen !== 1'b0 || obs_q[12].gen !== 1'b0 ||
        obs_q[13].gen !== 1'b1 || obs_q[11].idx !== 16'd1) begin
      errors++;
      $display("FAIL basic_gap: got gen c11..c14=%b%b%b%b idx c12=%0d expected 1001 idx 1",
               obs_q[10].gen, obs_q[11].gen, obs_q[12].gen, obs_q[13].gen, obs_q[11].idx);
    end
    checks++;
    if (obs_q[0].amp != 0.25 || obs_q[3].amp != 1.0 || obs_q[7].amp != 0.75 || obs_q[10].amp != 0.0) begin
      errors++;
      $display("FAIL basic_env: got %0.4f %0.4f %0.4f %0.4f expected 0.25 1.0 0.75 0.0",
               obs_q[0].amp, obs_q[3].amp, obs_q[7].amp, obs_q[10].amp);
    end
  endtask

  task automatic test_no_hold();
    run_seq(3, 0, 0, 30, -1, -1, 1'b0);
    build_exp(3, 0, 0, 30, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].gen !== exp_q[i].gen || obs_q[i].gate !== exp_q[i].gen ||
          obs_q[i].busy !== exp_q[i].busy || obs_q[i].done !== exp_q[i].done ||
          obs_q[i].idx !== exp_q[i].idx || rabs(obs_q[i].amp - exp_q[i].amp) > 1e-9) begin
        errors++;
        $display("FAIL nohold_trace cycle %0d: got gen=%b gate=%b busy=%b done=%b idx=%0d amp=%0.4f expected gen=%b busy=%b done=%b idx=%0d amp=%0.4f",
                 i + 1, obs_q[i].gen, obs_q[i].gate, obs_q[i].busy, obs_q[i].done, obs_q[i].idx, obs_q[i].amp,
                 exp_q[i].gen, exp_q[i].busy, exp_q[i].done, exp_q[i].idx, exp_q[i].amp);
      end
    end
    checks++;
    if (obs_q[26].done !== 1'b1 || obs_q[8].gen !== 1'b0 || obs_q[9].gen !== 1'b1) begin
      errors++;
      $display("FAIL nohold_done_at_27: got done=%b gap gen=%b next gen=%b expected 1 0 1",
               obs_q[26].done, obs_q[8].gen, obs_q[9].gen);
    end
  endtask

  task automatic test_zero_count();
    run_seq(0, 5, 5, 6, -1, -1, 1'b0);
    build_exp(0, 5, 5, 6, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].gen !== exp_q[i].gen || obs_q[i].gate !== exp_q[i].gen ||
          obs_q[i].busy !== exp_q[i].busy || obs_q[i].done !== exp_q[i].done ||
          obs_q[i].idx !== exp_q[i].idx || rabs(obs_q[i].amp - exp_q[i].amp) > 1e-9) begin
        errors++;
        $display("FAIL zero_trace cycle %0d: got gen=%b busy=%b done=%b idx=%0d amp=%0.4f expected gen=%b busy=%b done=%b idx=%0d amp=%0.4f",
                 i + 1, obs_q[i].gen, obs_q[i].busy, obs_q[i].done, obs_q[i].idx, obs_q[i].amp,
                 exp_q[i].gen, exp_q[i].busy, exp_q[i].done, exp_q[i].idx, exp_q[i].amp);
      end
    end
  endtask

  task automatic test_start_abort();
    @(posedge clk);
    #1;
    burst_count = 16'd2; on_cycles = 16'd3; off_cycles = 16'd2;
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (gen_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || amp_scale != 0.0) begin
        errors++;
        $display("FAIL start_abort cycle %0d: got gen=%b busy=%b done=%b amp=%0.4f expected all zero",
                 i, gen_rst_n, busy, done, amp_scale);
      end
    end
  endtask

  task automatic test_abort();
    run_seq(2, 3, 2, 26, 19, 6, 1'b0);
    build_exp(2, 3, 2, 26, 19);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].gen !== exp_q[i].gen || obs_q[i].gate !== exp_q[i].gen ||
          obs_q[i].busy !== exp_q[i].busy || obs_q[i].done !== exp_q[i].done ||
          obs_q[i].idx !== exp_q[i].idx || rabs(obs_q[i].amp - exp_q[i].amp) > 1e-9) begin
        errors++;
        $display("FAIL abort_trace cycle %0d: got gen=%b gate=%b busy=%b done=%b idx=%0d amp=%0.4f expected gen=%b busy=%b done=%b idx=%0d amp=%0.4f",
                 i + 1, obs_q[i].gen, obs_q[i].gate, obs_q[i].busy, obs_q[i].done, obs_q[i].idx, obs_q[i].amp,
                 exp_q[i].gen, exp_q[i].busy, exp_q[i].done, exp_q[i].idx, exp_q[i].amp);
      end
    end
    checks++;
    if (obs_q[19].done !== 1'b1 || obs_q[19].gen !== 1'b0 || obs_q[19].amp != 0.0 ||
        obs_q[19].idx !== 16'd1 || obs_q[20].done !== 1'b0 || obs_q[20].busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got done=%b gen=%b amp=%0.4f idx=%0d next done=%b busy=%b expected 1 0 0.0 1 0 0",
               obs_q[19].done, obs_q[19].gen, obs_q[19].amp, obs_q[19].idx, obs_q[20].done, obs_q[20].busy);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #1;
    burst_count = 16'd2; on_cycles = 16'd3; off_cycles = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 15; i++) @(negedge clk);
    checks++;
    if (gen_rst_n !== 1'b1 || burst_idx !== 16'd1 || amp_scale != 0.5) begin
      errors++;
      $display("FAIL areset_pre: got gen=%b idx=%0d amp=%0.4f expected 1 1 0.5", gen_rst_n, burst_idx, amp_scale);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gen_rst_n !== 1'b0 || gen_gate !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        burst_idx !== 16'd0 || amp_scale != 0.0) begin
      errors++;
      $display("FAIL areset_now: got gen=%b gate=%b busy=%b done=%b idx=%0d amp=%0.4f expected all zero",
               gen_rst_n, gen_gate, busy, done, burst_idx, amp_scale);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_hold: got done=%b busy=%b expected 0 0", done, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(2, 3, 2, 30, -1, -1, 1'b0);
    build_exp(2, 3, 2, 30, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].gen !== exp_q[i].gen || obs_q[i].gate !== exp_q[i].gen ||
          obs_q[i].busy !== exp_q[i].busy || obs_q[i].done !== exp_q[i].done ||
          obs_q[i].idx !== exp_q[i].idx || rabs(obs_q[i].amp - exp_q[i].amp) > 1e-9) begin
        errors++;
        $display("FAIL areset_replay cycle %0d: got gen=%b gate=%b busy=%b done=%b idx=%0d amp=%0.4f expected gen=%b busy=%b done=%b idx=%0d amp=%0.4f",
                 i + 1, obs_q[i].gen, obs_q[i].gate, obs_q[i].busy, obs_q[i].done, obs_q[i].idx, obs_q[i].amp,
                 exp_q[i].gen, exp_q[i].busy, exp_q[i].done, exp_q[i].idx, exp_q[i].amp);
      end
    end
  endtask

  task automatic test_random();
    int cnt, on, off, len, n, ab, st, lim;
    for (int it = 0; it < 25; it++) begin
      cnt = $urandom_range(1, 3);
      on  = $urandom_range(0, 5);
      off = $urandom_range(0, 3);
      len = cnt * (2 * R + on) + (cnt - 1) * ((off < 1) ? 1 : off);
      n   = len + 4;
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len + 1)) : -1;
      lim = (ab > 0) ? ab + 1 : len + 1;
      st  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, lim)) : -1;
      run_seq(cnt, on, off, n, ab, st, 1'b1);
      build_exp(cnt, on, off, n, ab);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].gen !== exp_q[i].gen || obs_q[i].gate !== exp_q[i].gen ||
            obs_q[i].busy !== exp_q[i].busy || obs_q[i].done !== exp_q[i].done ||
            obs_q[i].idx !== exp_q[i].idx || rabs(obs_q[i].amp - exp_q[i].amp) > 1e-9) begin
          errors++;
          $display("FAIL random it %0d (cnt=%0d on=%0d off=%0d abort=%0d start=%0d) cycle %0d: got gen=%b gate=%b busy=%b done=%b idx=%0d amp=%0.4f expected gen=%b busy=%b done=%b idx=%0d amp=%0.4f",
                   it, cnt, on, off, ab, st, i + 1,
                   obs_q[i].gen, obs_q[i].gate, obs_q[i].busy, obs_q[i].done, obs_q[i].idx, obs_q[i].amp,
                   exp_q[i].gen, exp_q[i].busy, exp_q[i].done, exp_q[i].idx, exp_q[i].amp);
        end
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    burst_count = '0;
    on_cycles   = '0;
    off_cycles  = '0;
    test_reset();
    test_basic();
    test_no_hold();
    test_zero_count();
    test_start_abort();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
